stream_frame_arbiter: RTL
=========================

# stream_frame_arbiter

Two-input AXI-Stream frame scheduler that shares the single 32-bit DMA-bound stream between two Zmod sample sources (e.g. ADC channel streams). It grants the output to one source for one whole frame of a programmable number of beats, injects `tlast` on the final beat, and tags every beat with source and frame metadata on `tuser`. It sits between the per-channel sample pipelines and the AXI DMA S2MM port.

## Interface
Parameters:
- `LEN_W`, 16, width of the frame-length input and internal beat counter.

Ports:
- `clk`  in  1  single clock for all logic.
- `resetn`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  1 = new frames may be granted; 0 = no new grant (a frame in progress completes).
- `frame_len`  in  LEN_W  beats per frame; sampled when a grant is issued; 0 = no grants.
- `s0_tvalid` / `s1_tvalid`  in  1  source valid.
- `s0_tready` / `s1_tready`  out  1  source ready.
- `s0_tdata` / `s1_tdata`  in  32  source data.
- `m0_tvalid`  out  1  output valid.
- `m0_tready`  in  1  output ready.
- `m0_tdata`  out  32  output data.
- `m0_tlast`  out  1  last beat of frame.
- `m0_tuser`  out  4  [0] source id, [1] start-of-frame, [3:2] global frame sequence mod 4.
- `busy`  out  1  1 while a frame is granted.
- `frame_count`  out  16  completed frames, wraps 0xFFFF -> 0.

## Operation
- FSM states: IDLE, BURST.
- IDLE: grant when `enable`=1, `frame_len`!=0, and at least one `sN_tvalid`=1. Exactly one valid -> grant it. Both valid -> grant the source not served last (`last_src`, reset 1 so s0 wins first). On grant: latch `src`, latch `len`=`frame_len`, clear `beat_cnt`, go BURST.
- BURST: `m0_tvalid`=`s[src]_tvalid`; `s[src]_tready`=`m0_tready`; other source `tready`=0; `m0_tdata`=`s[src]_tdata`.
- Beat = `m0_tvalid & m0_tready`. On each beat `beat_cnt`++.
- `m0_tuser[1]`=1 when `beat_cnt`==0; `m0_tlast`=1 when `beat_cnt`==`len`-1 (len=1: both on same beat).
- Beat with `m0_tlast`=1: `last_src`<=`src`, `seq`<=`seq`+1 (2-bit wrap), `frame_count`++, go IDLE.
- Frames are atomic: `enable` falling or `frame_len` changing mid-frame has no effect until the frame ends.
- Input streams carry no `tlast`; frame boundaries come only from this block.
- Outside BURST: both `sN_tready`=0, `m0_tvalid`=0, `m0_tdata`=0, `m0_tlast`=0, `m0_tuser`=0.
- `m0_tuser[0]`=`src`, `m0_tuser[3:2]`=`seq` during BURST.

## Timing
- Reset (async, immediate): state IDLE, `busy`=0, `frame_count`=0, `seq`=0, `last_src`=1, `beat_cnt`=0; all outputs 0. Reset mid-frame aborts the frame with no `tlast`.
- Grant decision registered: first beat can transfer the cycle after IDLE sees a valid request.
- Data path combinational from granted source: zero-cycle latency, no buffering; backpressure passes straight through.
- Exactly one IDLE cycle between consecutive frames (frame of N beats with no stalls occupies N+1 cycles).
- `busy`=1 exactly in BURST cycles.
- AXI-S rules: with `m0_tvalid`=1 and `m0_tready`=0, `m0_tdata`/`tlast`/`tuser` hold (sources obey AXI-S hold).

## Test plan
- Reset, `frame_len`=4, only s0 streaming 0x10.. continuously, `m0_tready`=1 -> frames of 4 beats, `tlast` on 0x13, 0x17; `tuser`=0x2 on first beat then 0x0, next frame `tuser[3:2]`=1; one-cycle gap between frames; `frame_count`=2.
- Both sources valid always, `frame_len`=3 -> frames alternate s0, s1, s0; `tuser[0]`=0,1,0; s1 `tready` never high during an s0 frame.
- `frame_len`=1 -> every beat has `tlast`=1 and `tuser[1]`=1; `frame_count` increments per beat.
- `frame_len`=5, `m0_tready` toggled 1/0 each cycle -> 5 beats over 10 cycles, output held stable during stalls, `tlast` only on 5th accepted beat.
- `enable` dropped after beat 2 of an 8-beat frame -> frame completes with 8 beats and `tlast`, then no further grants; `frame_len`=0 with valid inputs -> `busy` stays 0.
- `resetn` asserted at beat 3 of 6 -> all outputs 0 asynchronously; after release first grant goes to s0, `tuser[3:2]`=0, `frame_count`=0.

Source files
------------

// File: rtl/stream_frame_arbiter.sv
// Two-source AXI-Stream frame scheduler: grants one source per frame,
// injects tlast and tags each beat with source/frame metadata on tuser.
module stream_frame_arbiter #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             s0_tvalid,
  output logic             s0_tready,
  input  logic [31:0]      s0_tdata,
  input  logic             s1_tvalid,
  output logic             s1_tready,
  input  logic [31:0]      s1_tdata,
  output logic             m0_tvalid,
  input  logic             m0_tready,
  output logic [31:0]      m0_tdata,
  output logic             m0_tlast,
  output logic [3:0]       m0_tuser,
  output logic             busy,
  output logic [15:0]      frame_count
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_src;
  logic             r_last_src;
  logic [1:0]       r_seq;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_beat_cnt;

  logic w_grant;
  logic w_gnt_src;
  logic w_beat;
  logic w_done;
  logic w_last;
  logic w_sof;

  assign w_last = (r_beat_cnt == r_len - LEN_W'(1));
  assign w_sof  = (r_beat_cnt == '0);
  assign busy   = (r_state == BURST);

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_gnt_src   = 1'b0;
    w_beat      = 1'b0;
    w_done      = 1'b0;
    s0_tready   = 1'b0;
    s1_tready   = 1'b0;
    m0_tvalid   = 1'b0;
    m0_tdata    = '0;
    m0_tlast    = 1'b0;
    m0_tuser    = '0;
    unique case (r_state)
      IDLE: begin
        // On contention, serve whichever source did not get the last frame
        if (s0_tvalid && s1_tvalid)
          w_gnt_src = ~r_last_src;
        else
          w_gnt_src = s1_tvalid;
        if (enable && (frame_len != '0) &&
            (s0_tvalid || s1_tvalid)) begin
          w_grant     = 1'b1;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        m0_tvalid = r_src ? s1_tvalid : s0_tvalid;
        m0_tdata  = r_src ? s1_tdata : s0_tdata;
        s0_tready = !r_src && m0_tready;
        s1_tready = r_src && m0_tready;
        m0_tlast  = w_last;
        m0_tuser  = {r_seq, w_sof, r_src};
        w_beat    = m0_tvalid && m0_tready;
        w_done    = w_beat && w_last;
        if (w_done)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_src       <= 1'b0;
      r_last_src  <= 1'b1;
      r_seq       <= 2'd0;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      frame_count <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_src      <= w_gnt_src;
        r_len      <= frame_len;
        r_beat_cnt <= '0;
      end
      if (w_beat)
        r_beat_cnt <= r_beat_cnt + LEN_W'(1);
      if (w_done) begin
        r_last_src  <= r_src;
        r_seq       <= r_seq + 2'd1;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule
